// File: rtl/sm2201_mux_ctrl_pkg.sv
// Shared constants for the Sm2201 SN74LS298 mux-register controller:
// FSM encodings, word-select values and the interval timer width.
package sm2201_mux_ctrl_pkg;

  localparam int TIMER_W = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic WS_WORD1 = 1'b0;
  localparam logic WS_WORD2 = 1'b1;

endpackage

// File: rtl/sm2201_cycle_timer.sv
// Loadable down-counter with a zero flag; times both the word-select
// setup interval and the load-strobe width.
module sm2201_cycle_timer
  import sm2201_mux_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] count_q;

  // Load wins over decrement; the counter parks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/sm2201_mux_reg_arbiter.sv
// Round-robin arbiter sharing one SN74LS298 mux-register between two
// requesters: selects the word, waits out setup, strobes the load, acks.
module sm2201_mux_reg_arbiter
  import sm2201_mux_ctrl_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  output logic ws,
  output logic ld,
  output logic ack1,
  output logic ack2,
  output logic busy,
  output logic prio
);

  // The timer is only 4 bits wide, so reject intervals it cannot represent.
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : gSetupRangeCheck
    $error("SETUP_CYCLES must be in 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : gStrobeRangeCheck
    $error("STROBE_CYCLES must be in 1..15");
  end

  localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(SETUP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STROBE_LOAD = TIMER_W'(STROBE_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic               ws_q, ws_d;
  logic               ld_q, ld_d;
  logic               ack1_q, ack1_d;
  logic               ack2_q, ack2_d;
  logic               busy_q, busy_d;
  logic               prio_q, prio_d;
  logic               timerLoad;
  logic [TIMER_W-1:0] timerLoadVal;
  logic               timerDec;
  logic               timerZero;

  sm2201_cycle_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timerLoad),
    .load_val_i (timerLoadVal),
    .dec_i      (timerDec),
    .zero_o     (timerZero)
  );

  // ws_q doubles as the record of the granted side, so it may only move on IDLE->SETUP.
  always_comb begin
    state_d      = state_q;
    ws_d         = ws_q;
    ld_d         = ld_q;
    ack1_d       = ack1_q;
    ack2_d       = ack2_q;
    busy_d       = busy_q;
    prio_d       = prio_q;
    timerLoad    = 1'b0;
    timerLoadVal = '0;
    timerDec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req1 || req2) begin
          if (req1 && req2) begin
            ws_d = prio_q;
          end else if (req2) begin
            ws_d = WS_WORD2;
          end else begin
            ws_d = WS_WORD1;
          end
          busy_d       = 1'b1;
          timerLoad    = 1'b1;
          timerLoadVal = SETUP_LOAD;
          state_d      = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timerZero) begin
          ld_d         = 1'b1;
          timerLoad    = 1'b1;
          timerLoadVal = STROBE_LOAD;
          state_d      = ST_STROBE;
        end else begin
          timerDec = 1'b1;
        end
      end
      ST_STROBE: begin
        if (timerZero) begin
          ld_d    = 1'b0;
          ack1_d  = (ws_q == WS_WORD1);
          ack2_d  = (ws_q == WS_WORD2);
          state_d = ST_DONE;
        end else begin
          timerDec = 1'b1;
        end
      end
      ST_DONE: begin
        ack1_d  = 1'b0;
        ack2_d  = 1'b0;
        busy_d  = 1'b0;
        prio_d  = ~ws_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ws_q    <= WS_WORD1;
      ld_q    <= 1'b0;
      ack1_q  <= 1'b0;
      ack2_q  <= 1'b0;
      busy_q  <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_d;
      ld_q    <= ld_d;
      ack1_q  <= ack1_d;
      ack2_q  <= ack2_d;
      busy_q  <= busy_d;
      prio_q  <= prio_d;
    end
  end

  assign ws   = ws_q;
  assign ld   = ld_q;
  assign ack1 = ack1_q;
  assign ack2 = ack2_q;
  assign busy = busy_q;
  assign prio = prio_q;

endmodule

// File: doc/sm2201_mux_reg_arbiter.md
Name: sm2201_mux_reg_arbiter

Overview:
Controller that shares one SN74LS298 quad 2-input mux-register between two requesters on the Sm2201 ISA/CAMAC interface board. It arbitrates round-robin and drives the word-select line, then issues a timed load strobe to the register's clock input. Word-select is held stable for a programmable setup time before the strobe and held through the strobe. Each completed load is acknowledged to its requester.

Parameters:
SETUP_CYCLES, 2, clk cycles ws is stable before ld rises; legal 1..15
STROBE_CYCLES, 1, clk cycles ld stays high; legal 1..15

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req1  input  1  level request from requester 1 (word s1)
req2  input  1  level request from requester 2 (word s2)
ws  output  1  word select to mux-register; 0 = s1, 1 = s2
ld  output  1  load strobe to mux-register clock input
ack1  output  1  one-cycle pulse: requester 1 word loaded
ack2  output  1  one-cycle pulse: requester 2 word loaded
busy  output  1  high while a transaction is in progress
prio  output  1  requester favoured on next tie; 0 = req1, 1 = req2

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, ws=0, ld=0, ack1=0, ack2=0, busy=0, prio=0, timer=0.
- FSM states: IDLE, SETUP, STROBE, DONE.
- IDLE, no request: all outputs hold; ws keeps its last value.
- IDLE, any req high at edge N: grant goes to the single requester, or to the prio side if both are high.
  - At the same edge: ws <= granted side, busy <= 1, timer <= SETUP_CYCLES-1, next state SETUP.
- SETUP: timer decrements each edge. At the edge where timer==0: ld <= 1, timer <= STROBE_CYCLES-1, next state STROBE.
- STROBE: timer decrements each edge. At the edge where timer==0: ld <= 0, ack of the granted side <= 1, next state DONE.
- DONE, one cycle:
  - ack <= 0, busy <= 0.
  - prio <= opposite of the granted side (always, even if the other side was idle).
  - Next state IDLE.
- ws changes only on the IDLE->SETUP transition. It is stable from SETUP through DONE, which guarantees setup and hold around ld.
- Latency, req seen at edge N:
  - ws/busy valid after N
  - ld high from N+S to N+S+P, where S=SETUP_CYCLES and P=STROBE_CYCLES
  - ack high from N+S+P to N+S+P+1
  - busy low after N+S+P+1
  - next grant possible at edge N+S+P+2
  - Default transaction: 5 cycles, ld width 1.
- Requests are ignored outside IDLE. A req dropped mid-transaction does not abort it; ack is still issued.
- A req still high when IDLE is re-entered is served again as a new request.
- Simultaneous requests alternate strictly. A continuously held req1 and req2 produce grants 1,2,1,2,... when starting from prio=0.
- ack1 and ack2 are never high together. ld and any ack are never high together.
- Reset mid-transaction: at the reset edge ld, ack and busy go to 0, state goes to IDLE, prio goes to 0. No ack is issued for the aborted transaction.
- Timer is 4 bits. Out-of-range parameters are a configuration error; an elaboration check fails on 0 or >15.

Decomposition:
- Package sm2201_mux_ctrl_pkg:
  - FSM state encoding constants (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, DONE=2'd3)
  - WS_WORD1=1'b0, WS_WORD2=1'b1
  - timer width constant 4
- One sub-module is natural: sm2201_cycle_timer, a loadable 4-bit down-counter with a zero flag. It is used for both the SETUP and STROBE intervals.

Test Plan:
- Reset then req1=1 for one cycle (defaults) -> ws=0 after edge 0; ld=1 only in cycle 2-3; ack1 pulse in cycle 3-4; busy low after edge 4; ack2 never high.
- req1 and req2 held high from reset for 20 cycles -> grant order 1,2,1,2; one ld pulse per 5 cycles; ws toggles only at IDLE->SETUP, never while ld=1.
- SETUP_CYCLES=3, STROBE_CYCLES=2, req2 pulse -> ws=1 three cycles before ld rises; ld high exactly 2 cycles; ack2 follows on the cycle ld falls.
- req2 only, then req1 and req2 together -> second grant goes to req1 because prio=0 after the req2 transaction.
- rst asserted while ld=1 -> next edge gives ld=0, busy=0, prio=0, and no ack; a following req1 gives a full normal transaction.
- req1 dropped during SETUP -> transaction completes with ld pulse and ack1; no second transaction starts.
